slice_reader: RTL

SLICE_READER -- requirements
Module: slice_reader

---
 rtl/slice_reader_pkg.sv | 20 ++
 rtl/slice_reader_counter.sv | 29 ++
 rtl/slice_reader_fifo2.sv | 52 +++++
 rtl/slice_reader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/slice_reader_pkg.sv
// Shared definitions for the slice reader: slice geometry, FSM encoding and
// the width of a tagged FIFO entry.
package slice_reader_pkg;

  localparam int unsigned SLICE_W     = 25;
  localparam int unsigned SLICE_COUNT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // A FIFO entry carries the slice data with its address tag in the low bits.
  function automatic int unsigned fifo_width(input int unsigned cnt_bits);
    return SLICE_W + cnt_bits;
  endfunction

endpackage

// File: rtl/slice_reader_counter.sv
// Modulo-N up counter with synchronous clear; co flags the final count value.
module CounterModN #(
  parameter int unsigned N = 64,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         co
);

  localparam logic [W-1:0] Last = W'(N - 1);

  assign co = (q == Last);

  // Count up, wrapping after the final value; clear takes priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= co ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/slice_reader_fifo2.sv
// Two-entry FIFO; the head entry is presented combinationally on dout.
module slice_fifo2 #(
  parameter int unsigned W = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign dout    = entry[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; simultaneous push and pop keep cnt unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) entry[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= din;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/slice_reader.sv
// Streams the whole slice memory out as a valid/ready beat sequence.
//
//   state | meaning
//   IDLE  | waiting for start, no reads
//   RUN   | issuing reads while buffer + in-flight read leave room
//   DRAIN | all addresses issued, emptying the FIFO
//   FIN   | last beat accepted, done pulses for this one cycle
//
// First beat is visible two rising edges after the edge that samples start:
// read issued in RUN, data returned next cycle, pushed into the FIFO.
module slice_reader
  import slice_reader_pkg::*;
#(
  parameter int unsigned Count   = SLICE_COUNT,
  parameter int unsigned CntBits = $clog2(Count)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               memRead,
  output logic [CntBits-1:0] memAdr,
  input  logic [SLICE_W-1:0] memData,
  output logic               outValid,
  input  logic               outReady,
  output logic [SLICE_W-1:0] outData,
  output logic [CntBits-1:0] outIdx,
  output logic               outLast,
  output logic               busy,
  output logic               done
);

  localparam int unsigned        FifoW   = fifo_width(CntBits);
  localparam logic [CntBits-1:0] LastIdx = CntBits'(Count - 1);

  state_t             state;
  logic               adr_clr;
  logic               adr_en;
  logic               adr_co;
  logic               inflight;
  logic [CntBits-1:0] tag;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FifoW-1:0]   fifo_head;
  logic               pop;
  logic [1:0]         occ;
  logic [2:0]         load;

  assign occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pop  = outValid && outReady;
  // Counting the beat leaving this cycle is what lets a steady stream run back-to-back.
  assign load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign memRead = (state == RUN) && (load < 3'd2);
  assign adr_clr = (state == IDLE) && start;
  // Hold at the final address so it never wraps back to 0.
  assign adr_en  = memRead && !adr_co;

  assign outValid = !fifo_empty;
  assign outData  = fifo_head[FifoW-1:CntBits];
  assign outIdx   = fifo_head[CntBits-1:0];
  assign outLast  = outValid && (outIdx == LastIdx);

  CounterModN #(
    .N (Count),
    .W (CntBits)
  ) u_adr (
    .clk (clk),
    .rst (rst),
    .clr (adr_clr),
    .en  (adr_en),
    .q   (memAdr),
    .co  (adr_co)
  );

  slice_fifo2 #(
    .W (FifoW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({memData, tag}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Remember that a read is outstanding and which address it was for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= memRead;
      if (memRead) tag <= memAdr;
    end
  end

  // Sequencing FSM with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (memRead && adr_co) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && outLast) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
